// File: rtl/wb_fabric_slot_decoder.sv
// Wishbone slot decoder between the AHB-to-Fabric bridge and four fabric IP slots.
// Slot 3 is the default responder; defaulted transfers to slots 0-2 are counted and logged.
module wb_fabric_slot_decoder #(
  parameter int ADDRWIDTH   = 17,
  parameter int DATAWIDTH   = 32,
  parameter int TOCNT_WIDTH = 8
) (
  input  logic                   WBs_CLK_i,
  input  logic                   WBs_RST_i,
  input  logic [ADDRWIDTH-1:0]   WBs_ADR_i,
  input  logic                   WBs_CYC_i,
  input  logic                   WBs_STB_i,
  output logic [DATAWIDTH-1:0]   WBs_DAT_o,
  output logic                   WBs_ACK_o,
  output logic                   WBs_CYC_S0_o,
  output logic                   WBs_CYC_S1_o,
  output logic                   WBs_CYC_S2_o,
  output logic                   WBs_CYC_S3_o,
  input  logic [DATAWIDTH-1:0]   WBs_DAT_S0_i,
  input  logic [DATAWIDTH-1:0]   WBs_DAT_S1_i,
  input  logic [DATAWIDTH-1:0]   WBs_DAT_S2_i,
  input  logic [DATAWIDTH-1:0]   WBs_DAT_S3_i,
  input  logic                   WBs_ACK_S0_i,
  input  logic                   WBs_ACK_S1_i,
  input  logic                   WBs_ACK_S2_i,
  input  logic                   WBs_ACK_Res_i,
  output logic                   WBs_ACK_IP_o,
  input  logic                   Status_Clr_i,
  output logic [TOCNT_WIDTH-1:0] Timeout_Cnt_o,
  output logic [ADDRWIDTH-1:0]   Timeout_Adr_o,
  output logic                   Timeout_Flag_o
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t     state;
  state_t     state_next;
  logic [1:0] sel_q;
  logic [1:0] adr_slot;
  logic [1:0] slot;
  logic [2:0] user_ack;
  logic       sel_ack;
  logic       default_return;
  logic       timeout_event;
  logic       start;

  assign adr_slot = WBs_ADR_i[ADDRWIDTH-1:ADDRWIDTH-2];
  // The latched slot steers everything once a transfer is under way, so address wiggles are ignored.
  assign slot     = (state == ACTIVE) ? sel_q : adr_slot;

  assign user_ack     = {WBs_ACK_S2_i, WBs_ACK_S1_i, WBs_ACK_S0_i};
  assign WBs_ACK_IP_o = |user_ack;
  assign WBs_ACK_o    = WBs_ACK_IP_o | WBs_ACK_Res_i;

  assign WBs_CYC_S0_o = WBs_CYC_i & ~WBs_RST_i & (slot == 2'd0);
  assign WBs_CYC_S1_o = WBs_CYC_i & ~WBs_RST_i & (slot == 2'd1);
  assign WBs_CYC_S2_o = WBs_CYC_i & ~WBs_RST_i & (slot == 2'd2);
  assign WBs_CYC_S3_o = WBs_CYC_i & ~WBs_RST_i & (slot == 2'd3);

  always_comb begin
    sel_ack = 1'b0;
    case (slot)
      2'd0:    sel_ack = WBs_ACK_S0_i;
      2'd1:    sel_ack = WBs_ACK_S1_i;
      2'd2:    sel_ack = WBs_ACK_S2_i;
      default: sel_ack = 1'b0;
    endcase
  end

  // A responder ack without the user slot's own ack means the default value is being returned.
  assign default_return = (slot != 2'd3) & WBs_ACK_Res_i & ~sel_ack;
  assign timeout_event  = (state == ACTIVE) & default_return;

  always_comb begin
    WBs_DAT_o = WBs_DAT_S0_i;
    case (slot)
      2'd0:    WBs_DAT_o = WBs_DAT_S0_i;
      2'd1:    WBs_DAT_o = WBs_DAT_S1_i;
      2'd2:    WBs_DAT_o = WBs_DAT_S2_i;
      default: WBs_DAT_o = WBs_DAT_S3_i;
    endcase
    if (default_return) begin
      WBs_DAT_o = WBs_DAT_S3_i;
    end
  end

  assign start = WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (WBs_ACK_o || !WBs_CYC_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      state <= IDLE;
      sel_q <= 2'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        sel_q <= adr_slot;
      end
    end
  end

  // An event in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
    if (WBs_RST_i) begin
      Timeout_Cnt_o  <= '0;
      Timeout_Adr_o  <= '0;
      Timeout_Flag_o <= 1'b0;
    end else if (timeout_event) begin
      Timeout_Adr_o  <= WBs_ADR_i;
      Timeout_Flag_o <= 1'b1;
      if (Status_Clr_i) begin
        Timeout_Cnt_o <= TOCNT_WIDTH'(1);
      end else if (Timeout_Cnt_o != {TOCNT_WIDTH{1'b1}}) begin
        Timeout_Cnt_o <= Timeout_Cnt_o + TOCNT_WIDTH'(1);
      end
    end else if (Status_Clr_i) begin
      Timeout_Cnt_o  <= '0;
      Timeout_Adr_o  <= '0;
      Timeout_Flag_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_fabric_slot_decoder.sv
// Directed-vector bench for wb_fabric_slot_decoder: a per-cycle table plus
// hand sequences for counter saturation and reset during a transfer.
module tb_wb_fabric_slot_decoder;

  localparam logic [31:0] D0  = 32'hA0A0A0A0;
  localparam logic [31:0] D1  = 32'h12345678;
  localparam logic [31:0] D2  = 32'h22222222;
  localparam logic [31:0] DS3 = 32'hDEFFABAC;
  localparam logic [31:0] DR3 = 32'h00010000;
  localparam logic [16:0] A0  = 17'h00100;
  localparam logic [16:0] A1  = 17'h08040;
  localparam logic [16:0] A2  = 17'h10020;
  localparam logic [16:0] A3  = 17'h1FC00;
  localparam logic [16:0] AS  = 17'h00200;
  localparam logic [16:0] Z   = 17'h00000;

  typedef struct {
    logic [16:0] adr;
    logic        cyc;
    logic        stb;
    logic [2:0]  ack_s;
    logic        ack_res;
    logic        clr;
    logic [31:0] dat3;
    logic [3:0]  exp_cyc;
    logic        exp_ack;
    logic [31:0] exp_dat;
    logic        exp_ack_ip;
    logic [7:0]  exp_cnt;
    logic        exp_flag;
    logic [16:0] exp_adr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] adr = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        cyc_s0, cyc_s1, cyc_s2, cyc_s3;
  logic [31:0] dat_s3 = DS3;
  logic        ack_s0 = 1'b0, ack_s1 = 1'b0, ack_s2 = 1'b0, ack_res = 1'b0;
  logic        ack_ip;
  logic        clr = 1'b0;
  logic [7:0]  to_cnt;
  logic [16:0] to_adr;
  logic        to_flag;

  int vectors_applied = 0;
  int miscompares = 0;
  vec_t vecs[27];

  always #5 clk = ~clk;

  wb_fabric_slot_decoder #(.ADDRWIDTH(17), .DATAWIDTH(32), .TOCNT_WIDTH(8)) dut (
    .WBs_CLK_i(clk), .WBs_RST_i(rst), .WBs_ADR_i(adr), .WBs_CYC_i(cyc), .WBs_STB_i(stb),
    .WBs_DAT_o(dat_o), .WBs_ACK_o(ack_o),
    .WBs_CYC_S0_o(cyc_s0), .WBs_CYC_S1_o(cyc_s1), .WBs_CYC_S2_o(cyc_s2), .WBs_CYC_S3_o(cyc_s3),
    .WBs_DAT_S0_i(D0), .WBs_DAT_S1_i(D1), .WBs_DAT_S2_i(D2), .WBs_DAT_S3_i(dat_s3),
    .WBs_ACK_S0_i(ack_s0), .WBs_ACK_S1_i(ack_s1), .WBs_ACK_S2_i(ack_s2),
    .WBs_ACK_Res_i(ack_res), .WBs_ACK_IP_o(ack_ip), .Status_Clr_i(clr),
    .Timeout_Cnt_o(to_cnt), .Timeout_Adr_o(to_adr), .Timeout_Flag_o(to_flag)
  );

  function automatic vec_t mk(input logic [16:0] a, input logic c, input logic s,
                              input logic [2:0] ak, input logic r, input logic cl,
                              input logic [31:0] d3, input logic [3:0] ecyc,
                              input logic eack, input logic [31:0] edat, input logic eip,
                              input logic [7:0] ecnt, input logic eflag,
                              input logic [16:0] eadr);
    vec_t v;
    v.adr = a; v.cyc = c; v.stb = s; v.ack_s = ak; v.ack_res = r; v.clr = cl; v.dat3 = d3;
    v.exp_cyc = ecyc; v.exp_ack = eack; v.exp_dat = edat; v.exp_ack_ip = eip;
    v.exp_cnt = ecnt; v.exp_flag = eflag; v.exp_adr = eadr;
    return v;
  endfunction

  task automatic driveInputs(input vec_t v);
    adr = v.adr; cyc = v.cyc; stb = v.stb;
    {ack_s2, ack_s1, ack_s0} = v.ack_s;
    ack_res = v.ack_res; clr = v.clr; dat_s3 = v.dat3;
  endtask

  // Inputs change just after the rising edge; outputs are compared at the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    driveInputs(v);
    @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t v, input string name);
    logic [3:0] got_cyc;
    got_cyc = {cyc_s3, cyc_s2, cyc_s1, cyc_s0};
    vectors_applied++;
    if (got_cyc !== v.exp_cyc || ack_o !== v.exp_ack || dat_o !== v.exp_dat ||
        ack_ip !== v.exp_ack_ip || to_cnt !== v.exp_cnt || to_flag !== v.exp_flag ||
        to_adr !== v.exp_adr) begin
      miscompares++;
      $display("[TB] FAIL %s: got cyc=%b ack=%b dat=%h ip=%b cnt=%h flag=%b adr=%h, want cyc=%b ack=%b dat=%h ip=%b cnt=%h flag=%b adr=%h",
               name, got_cyc, ack_o, dat_o, ack_ip, to_cnt, to_flag, to_adr,
               v.exp_cyc, v.exp_ack, v.exp_dat, v.exp_ack_ip, v.exp_cnt, v.exp_flag, v.exp_adr);
    end
  endtask

  initial begin
    vec_t idle_v;
    //             adr cyc stb ack_s  res clr dat3 | cyc     ack dat  ip cnt    flg adr
    vecs[0]  = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd0, 0, Z);
    vecs[1]  = mk(A1, 1, 1, 3'b000, 0, 0, DS3, 4'b0010, 0, D1,  0, 8'd0, 0, Z);
    vecs[2]  = mk(A1, 1, 1, 3'b000, 0, 0, DS3, 4'b0010, 0, D1,  0, 8'd0, 0, Z);
    vecs[3]  = mk(A1, 1, 1, 3'b010, 0, 0, DS3, 4'b0010, 1, D1,  1, 8'd0, 0, Z);
    vecs[4]  = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd0, 0, Z);
    vecs[5]  = mk(A2, 1, 1, 3'b000, 0, 0, DS3, 4'b0100, 0, D2,  0, 8'd0, 0, Z);
    vecs[6]  = mk(A2, 1, 1, 3'b000, 1, 0, DS3, 4'b0100, 1, DS3, 0, 8'd0, 0, Z);
    vecs[7]  = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd1, 1, A2);
    vecs[8]  = mk(A3, 1, 1, 3'b000, 0, 0, DR3, 4'b1000, 0, DR3, 0, 8'd1, 1, A2);
    vecs[9]  = mk(A3, 1, 1, 3'b000, 1, 0, DR3, 4'b1000, 1, DR3, 0, 8'd1, 1, A2);
    vecs[10] = mk(Z,  0, 0, 3'b000, 0, 0, DR3, 4'b0000, 0, D0,  0, 8'd1, 1, A2);
    vecs[11] = mk(A0, 1, 1, 3'b000, 0, 0, DS3, 4'b0001, 0, D0,  0, 8'd1, 1, A2);
    vecs[12] = mk(A2, 1, 1, 3'b000, 0, 0, DS3, 4'b0001, 0, D0,  0, 8'd1, 1, A2);
    vecs[13] = mk(A2, 1, 1, 3'b001, 0, 0, DS3, 4'b0001, 1, D0,  1, 8'd1, 1, A2);
    vecs[14] = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd1, 1, A2);
    vecs[15] = mk(A1, 1, 1, 3'b000, 0, 0, DS3, 4'b0010, 0, D1,  0, 8'd1, 1, A2);
    vecs[16] = mk(A1, 1, 1, 3'b010, 1, 0, DS3, 4'b0010, 1, D1,  1, 8'd1, 1, A2);
    vecs[17] = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd1, 1, A2);
    vecs[18] = mk(A2, 1, 1, 3'b000, 0, 0, DS3, 4'b0100, 0, D2,  0, 8'd1, 1, A2);
    vecs[19] = mk(A2, 0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D2,  0, 8'd1, 1, A2);
    vecs[20] = mk(Z,  0, 0, 3'b000, 1, 0, DS3, 4'b0000, 1, DS3, 0, 8'd1, 1, A2);
    vecs[21] = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd1, 1, A2);
    vecs[22] = mk(A0, 1, 1, 3'b000, 0, 0, DS3, 4'b0001, 0, D0,  0, 8'd1, 1, A2);
    vecs[23] = mk(A0, 1, 1, 3'b000, 1, 1, DS3, 4'b0001, 1, DS3, 0, 8'd1, 1, A2);
    vecs[24] = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd1, 1, A0);
    vecs[25] = mk(Z,  0, 0, 3'b000, 0, 1, DS3, 4'b0000, 0, D0,  0, 8'd1, 1, A0);
    vecs[26] = mk(Z,  0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0,  0, 8'd0, 0, Z);

    @(negedge clk);
    checkOutput(vecs[0], "in_reset");
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], $sformatf("vec%0d", i));
    end

    // 256 defaulted transfers to slot 0 must pin the counter at all-ones.
    for (int n = 0; n < 256; n++) begin
      applyStimulus(mk(AS, 1, 1, 3'b000, 0, 0, DS3, 4'b0001, 0, D0, 0, 8'd0, 0, Z));
      applyStimulus(mk(AS, 1, 1, 3'b000, 1, 0, DS3, 4'b0001, 1, DS3, 0, 8'd0, 0, Z));
    end
    idle_v = mk(Z, 0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0, 0, 8'hFF, 1, AS);
    applyStimulus(idle_v);
    checkOutput(idle_v, "saturate_256");
    applyStimulus(mk(A2, 1, 1, 3'b000, 0, 0, DS3, 4'b0100, 0, D2, 0, 8'hFF, 1, AS));
    applyStimulus(mk(A2, 1, 1, 3'b000, 1, 0, DS3, 4'b0100, 1, DS3, 0, 8'hFF, 1, AS));
    idle_v = mk(Z, 0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0, 0, 8'hFF, 1, A2);
    applyStimulus(idle_v);
    checkOutput(idle_v, "saturate_hold");

    // Reset while ACTIVE on slot 1, then a stray responder ack that must not count.
    applyStimulus(mk(A1, 1, 1, 3'b000, 0, 0, DS3, 4'b0010, 0, D1, 0, 8'hFF, 1, A2));
    idle_v = mk(A1, 1, 1, 3'b000, 0, 0, DS3, 4'b0010, 0, D1, 0, 8'hFF, 1, A2);
    applyStimulus(idle_v);
    checkOutput(idle_v, "active_before_reset");
    #1 rst = 1'b1;
    #1;
    checkOutput(mk(A1, 1, 1, 3'b000, 0, 0, DS3, 4'b0000, 0, D1, 0, 8'd0, 0, Z), "reset_mid_transfer");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_v = mk(A1, 1, 1, 3'b000, 1, 0, DS3, 4'b0010, 1, DS3, 0, 8'd0, 0, Z);
    driveInputs(idle_v);
    @(negedge clk);
    checkOutput(idle_v, "stray_ack_after_reset");
    idle_v = mk(Z, 0, 0, 3'b000, 0, 0, DS3, 4'b0000, 0, D0, 0, 8'd0, 0, Z);
    applyStimulus(idle_v);
    checkOutput(idle_v, "stray_ack_not_counted");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
